mux_nch_reg: RTL and testbench
==============================

Name: mux_nch_reg

Overview:
Parametrised N-channel, WIDTH-bit multiplexer with a registered output stage and valid/ready handshakes on every input and on the output. It generalises the 1-bit, 2-input combinational mux. It supports two run-time modes: fixed select, or round-robin arbitration across channels. It sits between multiple producers and a single consumer, for example stream merging ahead of a shared datapath.

Parameters:
- WIDTH, 8, data bits per channel.
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, 2, width of the select and channel index; must equal ceil(log2(CHANNELS)).

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- rst_n, input, 1, synchronous active-low reset.
- in_data, input, CHANNELS*WIDTH, packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid, input, CHANNELS, per-channel valid.
- in_ready, output, CHANNELS, per-channel ready; combinational.
- mode, input, 1, 0 = fixed select, 1 = round-robin.
- sel, input, SEL_W, channel index used in fixed mode.
- out_data, output, WIDTH, registered output data.
- out_valid, output, 1, registered output valid.
- out_chan, output, SEL_W, index of the channel that produced out_data.
- out_ready, input, 1, downstream ready.
- xfer_cnt, output, 16, accepted-word counter (see Optional Feature).

Behaviour:
- Reset (rst_n low at a clk edge): out_valid=0, out_data=0, out_chan=0, rr_ptr=0, xfer_cnt=0. in_ready is all-zero while rst_n is low.
- Reset mid-operation: any held output word is discarded, with no out_valid pulse afterwards.
- Load enable: load = ~out_valid | out_ready. The output register accepts a new word whenever it is empty or is being drained in the same cycle. Full throughput is 1 word/cycle.
- Grant, fixed mode:
  - gnt = sel.
  - in_ready[sel] = load; all other in_ready bits are 0.
  - If sel >= CHANNELS, no channel is granted and in_ready is all-zero.
- Grant, round-robin mode:
  - gnt = first k with in_valid[k]=1, searching from rr_ptr upward and wrapping modulo CHANNELS.
  - in_ready[gnt] = load; all other bits are 0.
  - If no in_valid bit is set, no grant is made.
- Transfer: occurs on channel k when in_valid[k] & in_ready[k].
  - Next cycle: out_data = in_data[k], out_chan = k, out_valid = 1.
  - Latency from input accept to out_valid is exactly 1 cycle.
- Drain: if out_valid & out_ready and there is no new transfer, out_valid becomes 0 next cycle. out_data and out_chan hold their last values.
- Stall: while out_valid=1 and out_ready=0, out_data, out_chan and out_valid hold, and in_ready is all-zero.
- rr_ptr update:
  - Changes only on a transfer made in round-robin mode: rr_ptr = (gnt+1) mod CHANNELS, so CHANNELS-1 wraps to 0.
  - Holds in fixed mode and on idle cycles.
- Mode and sel are sampled combinationally every cycle. A change affects the next grant only and never alters a word already held.
- Simultaneous drain and load: the new word replaces the old one in the same edge, with no bubble.
- in_valid deasserted without ready is permitted and is not an error; the word is simply not taken.

Optional Feature:
- Macro MUX_NCH_STATS_EN.
- When defined: xfer_cnt increments by 1 on every input transfer and saturates at 16'hFFFF. It clears on reset.
- When not defined: xfer_cnt is tied to 16'h0000 and the counter logic is not built.
- Datapath behaviour is identical in both builds.

Test Plan:
1. Fixed mode, WIDTH=8, CHANNELS=4: mode=0, sel=2, all in_valid=1, data ch0..3 = 8'h10, 8'h20, 8'h30, 8'h40, out_ready=1.
   - in_ready=4'b0100.
   - Next cycle out_data=8'h30, out_chan=2, out_valid=1; repeats every cycle.
2. Round-robin fairness: mode=1, all four channels valid continuously, out_ready=1.
   - out_chan sequence is 0,1,2,3,0,1 over 6 consecutive cycles.
   - out_data matches the channel each cycle.
3. Round-robin skip and wrap: mode=1, in_valid=4'b1001, rr_ptr=0 after reset.
   - Grants go 0,3,0,3.
   - After a grant to 3, rr_ptr=0.
4. Backpressure: one word is accepted, then out_ready=0 for 3 cycles.
   - out_data and out_valid hold, and in_ready=0 throughout.
   - When out_ready=1, the next word appears on the following cycle with no loss or duplication.
5. Reset mid-stream: rst_n=0 for 1 cycle while out_valid=1.
   - Next cycle out_valid=0, out_data=0, out_chan=0.
   - The first round-robin grant afterwards is the lowest valid channel searching from 0.
6. Stats (MUX_NCH_STATS_EN defined): 10 transfers, then 2 stalled cycles.
   - xfer_cnt=10.
   - Build without the macro: xfer_cnt=0 for the same stimulus.

Source files
------------

// File: rtl/mux_nch_reg.sv
// mux_nch_reg: N-channel, WIDTH-bit multiplexer with a registered output stage
// and valid/ready handshakes on every input and on the output.
//
// Modes (sampled every cycle):
//   mode = 0 : fixed select, channel 'sel' is granted
//   mode = 1 : round-robin, first valid channel at or above rr_ptr (wrapping)
//
// Ports:
//   clk        - clock, all state updates on rising edge
//   rst_n      - synchronous active-low reset
//   in_data    - packed channel data, channel k at [k*WIDTH +: WIDTH]
//   in_valid   - per-channel valid
//   in_ready   - per-channel ready (combinational)
//   mode       - 0 fixed select, 1 round-robin
//   sel        - channel index used in fixed mode
//   out_data   - registered output data
//   out_valid  - registered output valid
//   out_chan   - index of the channel that produced out_data
//   out_ready  - downstream ready
//   xfer_cnt   - saturating accepted-word counter
//
// Optional feature: define MUX_NCH_STATS_EN to build the xfer_cnt counter;
// otherwise xfer_cnt is tied to zero.

module mux_nch_reg #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready,
  output logic [15:0]               xfer_cnt
);

  logic [WIDTH-1:0] ch_data [CHANNELS];

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             load;
  logic [SEL_W-1:0] gnt_rr;
  logic             gnt_rr_vld;
  logic [SEL_W-1:0] gnt;
  logic             gnt_vld;
  logic             xfer;
  int unsigned      idx;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
    assign ch_data[k] = in_data[k*WIDTH +: WIDTH];
  end

  // Output register can take a word when empty or being drained this cycle.
  assign load = ~out_valid_q | out_ready;

  // Round-robin search starting at rr_ptr, wrapping modulo CHANNELS.
  always_comb begin
    gnt_rr     = '0;
    gnt_rr_vld = 1'b0;
    idx        = 0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!gnt_rr_vld && in_valid[idx[SEL_W-1:0]]) begin
        gnt_rr     = idx[SEL_W-1:0];
        gnt_rr_vld = 1'b1;
      end
    end
  end

  always_comb begin
    if (mode) begin
      gnt     = gnt_rr;
      gnt_vld = gnt_rr_vld;
    end else begin
      gnt     = sel;
      gnt_vld = (32'(sel) < CHANNELS);
    end
  end

  always_comb begin
    in_ready = '0;
    if (rst_n && load && gnt_vld) in_ready[gnt] = 1'b1;
  end

  assign xfer = |(in_valid & in_ready);

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_data_d  = ch_data[gnt];
      out_chan_d  = gnt;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (xfer && mode) begin
      rr_ptr_d = (32'(gnt) == CHANNELS - 1) ? '0 : gnt + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

`ifdef MUX_NCH_STATS_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (xfer && (xfer_cnt_q != 16'hFFFF)) xfer_cnt_d = xfer_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) xfer_cnt_q <= 16'h0000;
    else        xfer_cnt_q <= xfer_cnt_d;
  end

  assign xfer_cnt = xfer_cnt_q;
`else
  assign xfer_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mux_nch_reg.sv
module tb_mux_nch_reg;

  typedef struct packed {
    logic [1:0] chan;
    logic [7:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [1:0]  out_chan;
  logic        out_ready;
  logic [15:0] xfer_cnt;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  mux_nch_reg #(
    .WIDTH    (8),
    .CHANNELS (4),
    .SEL_W    (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_chan  (out_chan),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] c, input logic [7:0] d);
    exp_t e;
    e.chan = c;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Inputs change 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Monitor: a word is consumed when out_valid & out_ready mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got chan %0d data %0h, expected no word", out_chan,
                 out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_chan", 32'(out_chan), 32'(e.chan));
        check("out_data", 32'(out_data), 32'(e.data));
      end
    end
  end

  initial begin
    logic [1:0] rr_exp [6];
    logic [1:0] sk_exp [4];
    logic [7:0] d;
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    sk_exp = '{2'd0, 2'd3, 2'd0, 2'd3};

    // Reset
    rst_n     = 1'b0;
    in_data   = {8'h40, 8'h30, 8'h20, 8'h10};
    in_valid  = 4'hF;
    mode      = 1'b1;
    sel       = 2'd0;
    out_ready = 1'b1;
    step();
    step();
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_chan", 32'(out_chan), 32'h0);
    check("rst_xfer_cnt", 32'(xfer_cnt), 32'h0);
    rst_n = 1'b1;

    // Fixed select, sel=2
    mode = 1'b0;
    sel  = 2'd2;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("fixed_in_ready", 32'(in_ready), 32'h4);
      push(2'd2, 8'h30);
      step();
      check("fixed_out_valid", 32'(out_valid), 32'h1);
    end

    // Round-robin fairness, all valid
    mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("rr_in_ready", 32'(in_ready), 32'h1 << rr_exp[i]);
      push(rr_exp[i], 8'h10 * (8'(rr_exp[i]) + 8'd1));
      step();
    end

    // Backpressure
    mode = 1'b0;
    sel  = 2'd1;
    #1;
    check("bp_accept_ready", 32'(in_ready), 32'h2);
    push(2'd1, 8'h20);
    step();
    out_ready = 1'b0;
    sel       = 2'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", 32'(in_ready), 32'h0);
      step();
      check("bp_hold_valid", 32'(out_valid), 32'h1);
      check("bp_hold_data", 32'(out_data), 32'h20);
      check("bp_hold_chan", 32'(out_chan), 32'h1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'h8);
    push(2'd3, 8'h40);
    step();
    in_valid = 4'h0;
    step();
    check("drain_valid", 32'(out_valid), 32'h0);
    check("drain_data_hold", 32'(out_data), 32'h40);
    check("drain_chan_hold", 32'(out_chan), 32'h3);

    // Reset mid-stream (rr_ptr is 2 here, so a held ch2 word is loaded)
    mode      = 1'b1;
    in_valid  = 4'hF;
    out_ready = 1'b0;
    #1;
    check("pre_rst_ready", 32'(in_ready), 32'h4);
    push(2'd2, 8'h30);
    step();
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    exp_q.delete(exp_q.size() - 1);
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'h0);
    step();
    check("mid_rst_out_valid", 32'(out_valid), 32'h0);
    check("mid_rst_out_data", 32'(out_data), 32'h0);
    check("mid_rst_out_chan", 32'(out_chan), 32'h0);
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Round-robin skip and wrap, rr_ptr=0 after reset
    in_valid = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("skip_in_ready", 32'(in_ready), 32'h1 << sk_exp[i]);
      push(sk_exp[i], (sk_exp[i] == 2'd0) ? 8'h10 : 8'h40);
      step();
    end
    in_valid = 4'hF;
    #1;
    check("wrap_in_ready", 32'(in_ready), 32'h1);
    push(2'd0, 8'h10);
    step();
    in_valid = 4'h0;
    step();
    check("wrap_drain_valid", 32'(out_valid), 32'h0);

    // Stats: 10 transfers, then 2 stalled cycles
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    mode     = 1'b0;
    sel      = 2'd0;
    in_valid = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      d = 8'hA0 + 8'(i);
      in_data[7:0] = d;
      push(2'd0, d);
      step();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("stall_in_ready", 32'(in_ready), 32'h0);
      step();
    end
`ifdef MUX_NCH_STATS_EN
    check("xfer_cnt", 32'(xfer_cnt), 32'd10);
`else
    check("xfer_cnt", 32'(xfer_cnt), 32'd0);
`endif
    check("stall_data_hold", 32'(out_data), 32'hA9);
    out_ready = 1'b1;
    in_valid  = 4'h0;
    step();
    check("final_valid", 32'(out_valid), 32'h0);
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
